// File: rtl/filter_det_pkg.sv
// Shared types and default widths for the filter threshold detector.
package filter_det_pkg;

    // Detector FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } det_state_e;

    // Event kind encoding carried on ev_kind
    localparam logic EV_RISE = 1'b0;
    localparam logic EV_FALL = 1'b1;

    // Default widths
    localparam int DEF_WIDTH = 8;
    localparam int DEF_HOLD  = 4;
    localparam int DEF_CNT_W = 16;
    localparam int RUN_W     = 8;

endpackage

// File: rtl/det_event_reg.sv
// One-entry valid/ready event register with sticky overflow on drop.
module det_event_reg
    import filter_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             fire,
    input  logic             kind,
    input  logic [CNT_W-1:0] stamp,
    input  logic [WIDTH-1:0] peak,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic             ev_kind,
    output logic [CNT_W-1:0] ev_stamp,
    output logic [WIDTH-1:0] ev_peak,
    output logic             overflow
);

    logic load_s;
    logic drop_s;

    // Load when empty or draining this cycle; otherwise a firing event is lost
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        if (fire) begin
            if (!ev_valid || ev_ready) begin
                load_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Holding register and sticky overflow flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ev_valid <= 1'b0;
            ev_kind  <= EV_RISE;
            ev_stamp <= {CNT_W{1'b0}};
            ev_peak  <= {WIDTH{1'b0}};
            overflow <= 1'b0;
        end else begin
            if (load_s) begin
                ev_valid <= 1'b1;
                ev_kind  <= kind;
                ev_stamp <= stamp;
                ev_peak  <= peak;
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_threshold_detector.sv
// Hysteresis threshold detector with consecutive-sample hold, sample
// timestamping and optional peak tracking (FILTER_DET_PEAK_EN).
module filter_threshold_detector
    import filter_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] hi_th,
    input  logic [WIDTH-1:0] lo_th,
    output logic             active,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             ev_kind,
    output logic [CNT_W-1:0] ev_stamp,
    output logic [WIDTH-1:0] ev_peak,
    output logic             overflow
);

    localparam logic [RUN_W-1:0] HOLD_C  = RUN_W'(HOLD);
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] IDX_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    det_state_e       state_r;
    det_state_e       state_nxt_s;
    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] run_nxt_s;
    logic [RUN_W-1:0] run_inc_s;
    logic [CNT_W-1:0] idx_r;
    logic             qual_hi_s;
    logic             qual_lo_s;
    logic             fire_s;
    logic             kind_s;
    logic [WIDTH-1:0] peak_evt_s;

    assign qual_hi_s = (in_data >= hi_th);
    assign qual_lo_s = (in_data <  lo_th);
    assign run_inc_s = run_r + RUN_ONE;

    // Next-state, run count and event strobe for the accepted sample
    always_comb begin
        state_nxt_s = state_r;
        run_nxt_s   = run_r;
        fire_s      = 1'b0;
        kind_s      = EV_RISE;
        if (in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (qual_hi_s) begin
                        if (HOLD_C == RUN_ONE) begin
                            state_nxt_s = ST_ACTIVE;
                            run_nxt_s   = {RUN_W{1'b0}};
                            fire_s      = 1'b1;
                            kind_s      = EV_RISE;
                        end else begin
                            state_nxt_s = ST_ARM;
                            run_nxt_s   = RUN_ONE;
                        end
                    end else begin
                        run_nxt_s = {RUN_W{1'b0}};
                    end
                end
                ST_ARM: begin
                    if (qual_hi_s) begin
                        if (run_inc_s == HOLD_C) begin
                            state_nxt_s = ST_ACTIVE;
                            run_nxt_s   = {RUN_W{1'b0}};
                            fire_s      = 1'b1;
                            kind_s      = EV_RISE;
                        end else begin
                            run_nxt_s = run_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                        run_nxt_s   = {RUN_W{1'b0}};
                    end
                end
                ST_ACTIVE: begin
                    if (qual_lo_s) begin
                        if (HOLD_C == RUN_ONE) begin
                            state_nxt_s = ST_IDLE;
                            run_nxt_s   = {RUN_W{1'b0}};
                            fire_s      = 1'b1;
                            kind_s      = EV_FALL;
                        end else begin
                            state_nxt_s = ST_RELEASE;
                            run_nxt_s   = RUN_ONE;
                        end
                    end else begin
                        run_nxt_s = {RUN_W{1'b0}};
                    end
                end
                ST_RELEASE: begin
                    if (qual_lo_s) begin
                        if (run_inc_s == HOLD_C) begin
                            state_nxt_s = ST_IDLE;
                            run_nxt_s   = {RUN_W{1'b0}};
                            fire_s      = 1'b1;
                            kind_s      = EV_FALL;
                        end else begin
                            run_nxt_s = run_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                        run_nxt_s   = {RUN_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    run_nxt_s   = {RUN_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            run_nxt_s   = run_r;
        end
    end

    // State, run counter, sample index and registered active level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            run_r   <= {RUN_W{1'b0}};
            idx_r   <= {CNT_W{1'b0}};
            active  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= run_nxt_s;
            active  <= (state_nxt_s == ST_ACTIVE) || (state_nxt_s == ST_RELEASE);
            if (in_valid) begin
                idx_r <= idx_r + IDX_ONE;
            end
        end
    end

`ifdef FILTER_DET_PEAK_EN
    logic [WIDTH-1:0] peak_r;
    logic [WIDTH-1:0] peak_cand_s;

    // peak_r is zero in IDLE, so the sample leaving IDLE seeds the max
    assign peak_cand_s = (in_data > peak_r) ? in_data : peak_r;
    assign peak_evt_s  = peak_cand_s;

    // Running max outside IDLE; cleared whenever IDLE is (re)entered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            peak_r <= {WIDTH{1'b0}};
        end else if (in_valid) begin
            if (state_nxt_s == ST_IDLE) begin
                peak_r <= {WIDTH{1'b0}};
            end else begin
                peak_r <= peak_cand_s;
            end
        end
    end
`else
    assign peak_evt_s = {WIDTH{1'b0}};
`endif

    det_event_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_event_reg (
        .CLK      (CLK),
        .RST      (RST),
        .fire     (fire_s),
        .kind     (kind_s),
        .stamp    (idx_r),
        .peak     (peak_evt_s),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_kind  (ev_kind),
        .ev_stamp (ev_stamp),
        .ev_peak  (ev_peak),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_filter_threshold_detector.sv
// Directed bench for filter_threshold_detector (HOLD=3, CNT_W=16 and CNT_W=4).
module tb_filter_threshold_detector;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic [7:0]  hi_th = 8'd100;
    logic [7:0]  lo_th = 8'd50;
    logic        ev_ready = 1'b1;
    logic        active, ev_valid, ev_kind, overflow;
    logic [15:0] ev_stamp;
    logic [7:0]  ev_peak;

    logic        in_valid4 = 1'b0;
    logic [7:0]  in_data4 = 8'd0;
    logic        active4, ev_valid4, ev_kind4, overflow4;
    logic [3:0]  ev_stamp4;
    logic [7:0]  ev_peak4;

    int chk_count  = 0;
    int fail_count = 0;

    always #5 CLK = ~CLK;

    filter_threshold_detector #(.WIDTH(8), .HOLD(3), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .hi_th(hi_th), .lo_th(lo_th), .active(active), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_stamp(ev_stamp),
        .ev_peak(ev_peak), .overflow(overflow)
    );

    filter_threshold_detector #(.WIDTH(8), .HOLD(3), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid4), .in_data(in_data4),
        .hi_th(hi_th), .lo_th(lo_th), .active(active4), .ev_valid(ev_valid4),
        .ev_ready(1'b1), .ev_kind(ev_kind4), .ev_stamp(ev_stamp4),
        .ev_peak(ev_peak4), .overflow(overflow4)
    );

    // Expected peak field: the value itself when peak tracking is built in
    function automatic logic [31:0] pk(input logic [7:0] v);
`ifdef FILTER_DET_PEAK_EN
        return {24'd0, v};
`else
        return (v == 8'd0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] d);
        @(negedge CLK);
        in_valid4 = 1'b1;
        in_data4  = d;
        @(posedge CLK);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_active",   {31'd0, active},   32'd0);
        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_stamp",    {16'd0, ev_stamp}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Rise: 20,120,130,140 -> RISE at index 3, peak 140
        send(8'd20);
        send(8'd120);
        send(8'd130);
        chk("arm_active",   {31'd0, active},   32'd0);
        chk("arm_no_event", {31'd0, ev_valid}, 32'd0);
        send(8'd140);
        chk("rise_active", {31'd0, active},   32'd1);
        chk("rise_valid",  {31'd0, ev_valid}, 32'd1);
        chk("rise_kind",   {31'd0, ev_kind},  32'd0);
        chk("rise_stamp",  {16'd0, ev_stamp}, 32'd3);
        chk("rise_peak",   {24'd0, ev_peak},  pk(8'd140));

        // Fall: 40,40,50(at lo_th, not qualifying),40,40,40 -> FALL at index 9
        send(8'd40);
        chk("drained_valid", {31'd0, ev_valid}, 32'd0);
        chk("release_active", {31'd0, active},  32'd1);
        send(8'd40);
        send(8'd50);
        send(8'd40);
        send(8'd40);
        chk("fall_pending", {31'd0, ev_valid}, 32'd0);
        send(8'd40);
        chk("fall_valid",  {31'd0, ev_valid}, 32'd1);
        chk("fall_kind",   {31'd0, ev_kind},  32'd1);
        chk("fall_stamp",  {16'd0, ev_stamp}, 32'd9);
        chk("fall_peak",   {24'd0, ev_peak},  pk(8'd140));
        chk("fall_active", {31'd0, active},   32'd0);

        // Fresh rise: 110,100(at hi_th, qualifying),101 -> RISE index 12, peak 110
        send(8'd110);
        send(8'd100);
        send(8'd101);
        chk("rise2_stamp", {16'd0, ev_stamp}, 32'd12);
        chk("rise2_peak",  {24'd0, ev_peak},  pk(8'd110));
        chk("rise2_kind",  {31'd0, ev_kind},  32'd0);

        // Backpressure: RISE held, later FALL dropped
        ev_ready = 1'b0;
        send(8'd40);
        send(8'd40);
        send(8'd40);
        chk("ovf_flag",  {31'd0, overflow}, 32'd1);
        chk("ovf_valid", {31'd0, ev_valid}, 32'd1);
        chk("ovf_kind",  {31'd0, ev_kind},  32'd0);
        chk("ovf_stamp", {16'd0, ev_stamp}, 32'd12);
        chk("ovf_active", {31'd0, active},  32'd0);
        @(negedge CLK);
        ev_ready = 1'b1;
        idle_cycle();
        chk("consume_valid", {31'd0, ev_valid}, 32'd0);
        chk("sticky_ovf",    {31'd0, overflow}, 32'd1);

        // Asynchronous reset mid-ARM
        send(8'd120);
        send(8'd130);
        #2;
        RST = 1'b1;
        #1;
        chk("async_overflow", {31'd0, overflow}, 32'd0);
        chk("async_stamp",    {16'd0, ev_stamp}, 32'd0);
        chk("async_kind",     {31'd0, ev_kind},  32'd0);
        chk("async_peak",     {24'd0, ev_peak},  32'd0);
        chk("async_active",   {31'd0, active},   32'd0);
        RST = 1'b0;

        // Broken run: 120,130,90,120,120,120 -> single RISE at index 5
        send(8'd120);
        send(8'd130);
        chk("broken_no_ev1", {31'd0, ev_valid}, 32'd0);
        send(8'd90);
        chk("broken_no_ev2", {31'd0, ev_valid}, 32'd0);
        chk("broken_idle",   {31'd0, active},   32'd0);
        send(8'd120);
        send(8'd120);
        chk("broken_no_ev3", {31'd0, ev_valid}, 32'd0);
        send(8'd120);
        chk("broken_valid", {31'd0, ev_valid}, 32'd1);
        chk("broken_stamp", {16'd0, ev_stamp}, 32'd5);
        chk("broken_peak",  {24'd0, ev_peak},  pk(8'd120));

        // CNT_W=4 wrap: 15 low samples, 3 high with gaps, RISE at 18th sample -> stamp 1
        for (int i = 0; i < 15; i++) begin
            send4(8'd10);
            if (i % 4 == 1) begin
                idle_cycle();
            end
        end
        send4(8'd200);
        idle_cycle();
        send4(8'd150);
        idle_cycle();
        idle_cycle();
        chk("wrap_no_event", {31'd0, ev_valid4}, 32'd0);
        send4(8'd180);
        chk("wrap_valid",  {31'd0, ev_valid4}, 32'd1);
        chk("wrap_stamp",  {28'd0, ev_stamp4}, 32'd1);
        chk("wrap_kind",   {31'd0, ev_kind4},  32'd0);
        chk("wrap_peak",   {24'd0, ev_peak4},  pk(8'd200));
        chk("wrap_active", {31'd0, active4},   32'd1);
        send4(8'd10);
        send4(8'd10);
        chk("wrap_ovf", {31'd0, overflow4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
        $finish;
    end

endmodule
